// File: rtl/hill_pkg.sv
// hill_pkg: shared constants, character helpers and FSM states for the Hill cipher engine
package hill_pkg;

    localparam int         MOD    = 26;
    localparam logic [7:0] A_BASE = "A";

    typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

    function automatic logic is_letter(input logic [7:0] ch);
        return (ch >= "A" && ch <= "Z") || (ch >= "a" && ch <= "z");
    endfunction

    function automatic logic [4:0] char_to_num(input logic [7:0] ch);
        return ch >= "a" ? 5'(ch - "a") : 5'(ch - "A");
    endfunction

    // Constant-divisor modulo; the operand never exceeds 650
    function automatic logic [4:0] mod26_reduce(input logic [9:0] s);
        return 5'(s % 10'(MOD));
    endfunction

endpackage

// File: rtl/hill_mod_mac.sv
// hill_mod_mac: one mod-26 multiply-accumulate step with a registered accumulator
module hill_mod_mac
    import hill_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [4:0] sum
);

    logic [4:0] acc;

    // sum is the value acc takes this cycle, so a row result can be captured on its last column
    assign sum = mod26_reduce(10'(clr ? 5'd0 : acc) + 10'(a) * 10'(b));

    // accumulator register
    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else if (en) acc <= sum;
    end

endmodule

// File: rtl/hill_cipher_stream.sv
// hill_cipher_stream: streaming block Hill cipher C = K*P mod 26 with padding and dual key banks
module hill_cipher_stream
    import hill_pkg::*;
#(
    parameter int         BLOCK_SIZE = 3,
    parameter int         DATA_WIDTH = 8,
    parameter logic [7:0] PAD_CHAR   = "X"
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [4:0]                                 key_data,
    input  logic [$clog2(BLOCK_SIZE*BLOCK_SIZE)-1:0]   key_addr,
    input  logic                                       key_bank,
    input  logic                                       key_wen,
    input  logic                                       mode,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    input  logic                                       in_valid,
    input  logic                                       in_last,
    output logic                                       in_ready,
    output logic [DATA_WIDTH-1:0]                      out_data,
    output logic                                       out_valid,
    output logic                                       out_last,
    input  logic                                       out_ready,
    output logic                                       busy,
    output logic                                       bad_char
);

    localparam int N  = BLOCK_SIZE;
    localparam int NN = N * N;
    localparam int AW = $clog2(NN);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] r, c, i;
    logic          mode_l, is_last;
    logic [4:0]    ke [NN];
    logic [4:0]    kd [NN];
    logic [4:0]    p  [N];
    logic [4:0]    res[N];
    logic [7:0]    ch;
    logic          letter, accept, close, done;
    logic [4:0]    num, pad, mac_a, mac_sum;
    logic [AW-1:0] kidx;

    assign ch     = 8'(in_data);
    assign letter = is_letter(ch);
    assign num    = char_to_num(ch);
    assign pad    = char_to_num(PAD_CHAR);
    assign accept = in_valid && state == COLLECT;
    assign cnt_n  = cnt + CW'(letter);
    assign close  = accept && (in_last || cnt_n == CW'(N));
    assign done   = state == EMIT && out_ready && i == LAST;
    assign kidx   = AW'(int'(r) * N + int'(c));
    assign mac_a  = mode_l ? kd[kidx] : ke[kidx];

    hill_mod_mac u_mac (
        .clk (clk),
        .rst (rst),
        .clr (c == '0),
        .en  (state == COMPUTE),
        .a   (mac_a),
        .b   (p[c]),
        .sum (mac_sum)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? COLLECT : state_n;
    end

    // next state and handshake outputs
    always_comb begin
        state_n   = state;
        in_ready  = state == COLLECT;
        busy      = state != COLLECT || cnt != '0;
        out_valid = state == EMIT;
        out_last  = state == EMIT && is_last && i == LAST;
        out_data  = state == EMIT ? DATA_WIDTH'(8'(res[i]) + A_BASE) : '0;
        if (state == COLLECT && close) state_n = COMPUTE;
        else if (state == COMPUTE && r == LAST && c == LAST) state_n = EMIT;
        else if (done) state_n = COLLECT;
    end

    // input buffer with tail padding, MAC sequencing, result capture and emit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            r        <= '0;
            c        <= '0;
            i        <= '0;
            mode_l   <= 1'b0;
            is_last  <= 1'b0;
            bad_char <= 1'b0;
            for (int k = 0; k < N; k++) begin
                p[k]   <= '0;
                res[k] <= '0;
            end
        end else begin
            if (accept) begin
                cnt <= cnt_n;
                if (!letter) bad_char <= 1'b1;
                for (int k = 0; k < N; k++) begin
                    if (letter && CW'(k) == cnt) p[k] <= num;
                    else if (in_last && CW'(k) >= cnt_n) p[k] <= pad;
                end
            end
            if (close) begin
                mode_l  <= mode;
                is_last <= in_last;
            end
            if (state == COMPUTE) begin
                c <= c == LAST ? '0 : c + 1'b1;
                if (c == LAST) begin
                    r      <= r == LAST ? '0 : r + 1'b1;
                    res[r] <= mac_sum;
                end
            end
            if (state == EMIT && out_ready) i <= i == LAST ? '0 : i + 1'b1;
            if (done) begin
                cnt <= '0;
                if (is_last) bad_char <= 1'b0;
            end
        end
    end

    // key banks: identity on reset, host writes only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) begin
                ke[k] <= k % (N + 1) == 0 ? 5'd1 : 5'd0;
                kd[k] <= k % (N + 1) == 0 ? 5'd1 : 5'd0;
            end
        end else if (key_wen && !busy && int'(key_addr) < NN) begin
            if (key_bank) kd[key_addr] <= key_data;
            else ke[key_addr] <= key_data;
        end
    end

endmodule
